ad7656_cfg_sequencer: RTL
=========================

Name: ad7656_cfg_sequencer

Overview:
- Upstream feeder of the AD7656 parallel write driver. It generates that driver's wr_flag/wr_data and consumes its bus_busy.
- Accepts 8-bit control-register words from host/config logic through a valid/ready FIFO.
- Enforces a power-up wait, then writes DEFAULT_CFG once, then serialises queued writes one at a time with a minimum inter-write gap.
- Reports done, overflow-free backpressure and a bus-handshake timeout error.

Parameters:
- PWRUP_CYCLES, 10000: sys_clk cycles to wait after reset before the first write (100 us at 100 MHz); minimum 1.
- GAP_CYCLES, 4: idle cycles after bus_busy falls before the next write may issue; 0 allowed.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, at least 2.
- DEFAULT_CFG, 8'h00: control word written automatically once after power-up.
- BUSY_TIMEOUT, 8: cycles allowed for bus_busy_i to rise after wr_flag_o.

Ports:
- sys_clk_i  in  1  100 MHz system clock
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  host write request
- cfg_data_i  in  8  control word (driven onto DB[15:8] by the driver)
- cfg_ready_o  out  1  FIFO not full; a transfer occurs when valid && ready
- bus_busy_i  in  1  busy from the write driver
- wr_flag_o  out  1  one-cycle write-start pulse to the driver
- wr_data_o  out  8  word for the driver; valid on the wr_flag_o cycle
- cfg_done_o  out  1  power-up complete, FIFO empty, FSM in IDLE
- err_timeout_o  out  1  sticky; bus_busy_i failed to rise in time
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, sys_clk_i. Reset is synchronous, active-high (rst_i), sampled on the sys_clk_i rising edge.
- Reset values: wr_flag_o=0, wr_data_o=0, cfg_done_o=0, err_timeout_o=0, fifo_level_o=0, FIFO emptied, FSM=PWRUP, counters=0. cfg_ready_o=1 from the first cycle after reset, so the host may queue writes during PWRUP.
- Reset mid-write: aborts immediately; no further wr_flag_o pulse. The driver's own cycle completes independently.
- FSM states: PWRUP, DEFAULT, IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP.
- PWRUP: counts PWRUP_CYCLES cycles, then goes to DEFAULT.
- DEFAULT: loads wr_data_o=DEFAULT_CFG, then goes to ISSUE. This state is entered only once per reset.
- IDLE: if the FIFO is not empty, pops the head into wr_data_o and goes to ISSUE; otherwise stays in IDLE. cfg_done_o=1 only in IDLE with the FIFO empty.
- ISSUE: wr_flag_o=1 for exactly this one cycle, then goes to WAIT_HI. wr_data_o is held stable until the next ISSUE.
- WAIT_HI: waits for bus_busy_i=1, then goes to WAIT_LO. If it waits BUSY_TIMEOUT cycles without seeing busy, sets err_timeout_o=1 and goes to GAP; the word is dropped, not retried.
- WAIT_LO: waits for bus_busy_i=0, then goes to GAP. There is no timeout in this state.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE. GAP_CYCLES=0 means GAP goes to IDLE after one cycle.
- Write-to-write spacing: the minimum flag-to-flag spacing is 1 + busy latency + busy length + GAP + 2 cycles. Against the 4-cycle-busy driver with GAP_CYCLES=4, this gives 12 cycles.
- FIFO rules: first-word fall-through is not required. The pop happens in IDLE and the data is registered into wr_data_o.
- Simultaneous push and pop: level is unchanged, and push is accepted even when the FIFO is full on that cycle.
- Full FIFO: cfg_ready_o=0. Data is never dropped; the host must hold valid.
- Pointers wrap modulo FIFO_DEPTH.
- err_timeout_o clears only on reset.

Optional Feature:
- Macro: AD7656_CFG_DEDUP_EN.
- When defined: in IDLE, a popped word equal to the last word actually issued is discarded. No ISSUE or GAP occurs and the FSM stays in IDLE.
- The last-issued register resets to DEFAULT_CFG once the DEFAULT write has issued; it is invalid before that.
- When undefined: every accepted word is written, including repeats.

Test Plan:
- Power-up timing: reset 5 cycles, PWRUP_CYCLES=20, bus model with busy high for 4 cycles starting 1 cycle after the flag -> first wr_flag_o 21 cycles after reset release, wr_data_o=8'h00; cfg_done_o rises after GAP.
- Back-to-back burst: push 8'hA1, 8'hB2, 8'hC3 during PWRUP -> writes issued in order DEFAULT, A1, B2, C3; flags spaced exactly 12 cycles apart.
- Backpressure and wrap: FIFO_DEPTH=4, hold valid for 6 words 8'h10..8'h15 while the bus is busy -> cfg_ready_o low when level=4; all 6 written in order; no loss across pointer wrap.
- Bus timeout: bus model never asserts busy -> err_timeout_o=1 BUSY_TIMEOUT cycles after the flag; the next queued word still issues after GAP.
- Mid-operation reset: assert rst_i during WAIT_LO with 2 words queued -> outputs return to reset values next cycle; fifo_level_o=0; the next flag is DEFAULT after PWRUP.
- Dedup (macro defined): push 8'h00, 8'h55, 8'h55, 8'h66 -> only DEFAULT, 55, 66 are written. Macro undefined: 5 writes.

Source files
------------

// File: rtl/ad7656_cfg_sequencer.sv
// Power-up sequencer and write serialiser feeding the AD7656 parallel write driver.
// Optional build macro AD7656_CFG_DEDUP_EN drops popped words equal to the last issued word.
module ad7656_cfg_sequencer #(
  parameter int          PWRUP_CYCLES = 10000,
  parameter int          GAP_CYCLES   = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  DEFAULT_CFG  = 8'h00,
  parameter int          BUSY_TIMEOUT = 8
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  input  logic [7:0]                    cfg_data_i,
  output logic                          cfg_ready_o,
  input  logic                          bus_busy_i,
  output logic                          wr_flag_o,
  output logic [7:0]                    wr_data_o,
  output logic                          cfg_done_o,
  output logic                          err_timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CM0  = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CMAX = (CM0 > BUSY_TIMEOUT) ? CM0 : BUSY_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1) + 1;

  typedef enum logic [2:0] {
    S_PWRUP, S_DEFAULT, S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            err_q, err_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            pop, push, full, dup;
  logic [7:0]      head;

  assign head = mem_q[rptr_q];

`ifdef AD7656_CFG_DEDUP_EN
  logic [7:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;

  assign dup = last_vld_q && (head == last_q);

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (state_q == S_ISSUE) begin
      last_d     = wr_data_q;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      last_q     <= DEFAULT_CFG;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  always_comb begin
    full        = (level_q == LW'(FIFO_DEPTH));
    cfg_ready_o = !full || pop;
    push        = cfg_valid_i && cfg_ready_o;
    wptr_d      = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d      = pop  ? rptr_q + AW'(1) : rptr_q;
    level_d     = level_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
          state_d = S_DEFAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEFAULT: begin
        wr_data_d = DEFAULT_CFG;
        state_d   = S_ISSUE;
      end
      S_IDLE: begin
        if (level_q != '0) begin
          pop = 1'b1;
          if (!dup) begin
            wr_data_d = head;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // cnt counts cycles since the flag, so the timeout covers the flag cycle too
        state_d = S_WAIT_HI;
        cnt_d   = CW'(1);
      end
      S_WAIT_HI: begin
        if (bus_busy_i) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!bus_busy_i) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q   <= S_PWRUP;
      cnt_q     <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      level_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      level_q   <= level_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wptr_q] <= cfg_data_i;
  end

  assign wr_flag_o     = (state_q == S_ISSUE);
  assign wr_data_o     = wr_data_q;
  assign cfg_done_o    = (state_q == S_IDLE) && (level_q == '0);
  assign err_timeout_o = err_q;
  assign fifo_level_o  = level_q;

endmodule
